// File: rtl/air_conditioning.sv
// Thermostat controller for one heating/cooling zone.
// Compares the signed Q8.8 setpoint (I1) against the measured temperature (I2)
// with a hysteresis dead band and drives mutually exclusive heat/cool demands.
// Build option: define AC_MIN_DWELL_EN to add the minimum-dwell counter that
// holds every state for at least MIN_DWELL cycles before it may be left.
//
// state | meaning
// ------+--------------------------------------------------------
// IDLE  | no demand; waits for I2 to leave the band [I1-HYST, I1+HYST]
// HEAT  | heating demand; held until I2 climbs back to I1
// COOL  | cooling demand; held until I2 falls back to I1
module air_conditioning #(
    parameter int                        DATA_W    = 16,
    parameter int                        FRAC_W    = 8,
    parameter logic signed [DATA_W-1:0]  HYST      = 16'sd128,
    parameter int                        MIN_DWELL = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] I1,
    input  logic [DATA_W-1:0] I2,
    output logic              heat,
    output logic              cool
);

    // Two guard bits keep I1 +/- HYST free of overflow.
    localparam int EXT_W = DATA_W + 2;
    localparam int CNT_W = (MIN_DWELL < 1) ? 1 : $clog2(MIN_DWELL + 1);

    // Reject parameter sets the datapath was not sized for.
    generate
        if (MIN_DWELL < 1 || FRAC_W >= DATA_W || HYST < 0 ||
            int'(HYST) >= (2 ** (DATA_W - 2))) begin : g_param_chk
            $error("air_conditioning: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAT = 2'd1,
        ST_COOL = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic signed [EXT_W-1:0] sp_x, tm_x, hyst_x, lo_x, hi_x;
    logic                    may_leave;

    assign sp_x   = {{2{I1[DATA_W-1]}}, I1};
    assign tm_x   = {{2{I2[DATA_W-1]}}, I2};
    assign hyst_x = {2'b00, HYST};
    assign lo_x   = sp_x - hyst_x;
    assign hi_x   = sp_x + hyst_x;

`ifdef AC_MIN_DWELL_EN
    logic [CNT_W-1:0] dwell_q, dwell_d;

    // Dwell count restarts on every state change and saturates at MIN_DWELL.
    always_comb begin
        dwell_d = dwell_q;
        if (state_d != state_q) begin
            dwell_d = '0;
        end else if (dwell_q != CNT_W'(MIN_DWELL)) begin
            dwell_d = dwell_q + CNT_W'(1);
        end
    end

    // Dwell counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q <= '0;
        end else begin
            dwell_q <= dwell_d;
        end
    end

    assign may_leave = (dwell_q == CNT_W'(MIN_DWELL));
`else
    assign may_leave = 1'b1;
`endif

    // Next-state logic: band exits from IDLE, return to IDLE at the setpoint.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (tm_x < lo_x) begin
                    state_d = ST_HEAT;
                end else if (tm_x > hi_x) begin
                    state_d = ST_COOL;
                end
            end
            ST_HEAT: begin
                if (tm_x >= sp_x) begin
                    state_d = ST_IDLE;
                end
            end
            ST_COOL: begin
                if (tm_x <= sp_x) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (!may_leave) begin
            state_d = state_q;
        end
    end

    // State register; reset forces IDLE regardless of dwell.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign heat = (state_q == ST_HEAT);
    assign cool = (state_q == ST_COOL);

endmodule

// File: tb/tb_air_conditioning.sv
// Bench for air_conditioning: directed scenarios followed by randomized
// setpoint/temperature traffic, checked each cycle against a demand model
// expressed directly in integer degrees-times-256.
module tb_air_conditioning;

    localparam int HYST_TB      = 128;
    localparam int MIN_DWELL_TB = 4;

    logic               clk;
    logic               reset;
    logic signed [15:0] I1;
    logic signed [15:0] I2;
    logic               heat;
    logic               cool;

    int n_checks;
    int n_errors;

    // Reference model: demand is 0 none, 1 heating, 2 cooling.
    int demand;
    int held;

    air_conditioning #(
        .DATA_W   (16),
        .FRAC_W   (8),
        .HYST     (16'(HYST_TB)),
        .MIN_DWELL(MIN_DWELL_TB)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .I1   (I1),
        .I2   (I2),
        .heat (heat),
        .cool (cool)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Advance the model by one rising edge using the values presented on it.
    task automatic model_edge();
        int sp, t, want;
        bit allowed;
        sp = int'(I1);
        t  = int'(I2);
        if (reset) begin
            demand = 0;
            held   = 0;
        end else begin
            want = demand;
            if (demand == 0) begin
                if (t < sp - HYST_TB)      want = 1;
                else if (t > sp + HYST_TB) want = 2;
            end else if (demand == 1) begin
                if (t >= sp) want = 0;
            end else begin
                if (t <= sp) want = 0;
            end
`ifdef AC_MIN_DWELL_EN
            allowed = (held >= MIN_DWELL_TB);
`else
            allowed = 1'b1;
`endif
            if (want != demand && allowed) begin
                demand = want;
                held   = 0;
            end else if (held < 1000) begin
                held++;
            end
        end
    endtask

    // Present inputs, clock one edge, then compare outputs half a cycle later.
    task automatic step(input logic r, input int sp, input int t);
        reset = r;
        I1    = 16'(sp);
        I2    = 16'(t);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        chk("heat", int'(heat), (demand == 1) ? 1 : 0);
        chk("cool", int'(cool), (demand == 2) ? 1 : 0);
        chk("excl", int'(heat & cool), 0);
    endtask

    initial begin
        int sp, off, sel;
        n_checks = 0;
        n_errors = 0;
        demand   = 0;
        held     = 0;
        reset    = 1'b1;
        I1       = '0;
        I2       = '0;
        @(negedge clk);

        // Reset state.
        step(1'b1, 16'h1A00, 16'h1200);
        chk("rst_heat", int'(heat), 0);
        chk("rst_cool", int'(cool), 0);

        // Cold zone -> heating, then ramp up to the setpoint.
        for (int i = 0; i < 8; i++) step(1'b0, 16'h1A00, 16'h1200);
        for (int t = 16'h1200; t <= 16'h1B00; t += 16'h0080) step(1'b0, 16'h1A00, t);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h1A00, 16'h1A00);

        // Exactly at the upper threshold stays idle; one LSB above cools.
        for (int i = 0; i < 8; i++) step(1'b0, 16'h1A00, 16'h1A80);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h1A00, 16'h1A81);

        // Reverse from cooling straight to a cold reading.
        for (int i = 0; i < 12; i++) step(1'b0, 16'h1A00, 16'h1000);

        // Enter heating then immediately satisfy the setpoint.
        for (int i = 0; i < 8; i++) step(1'b0, 16'h1A00, 16'h1A00);
        step(1'b0, 16'h1A00, 16'h1000);
        while (demand != 1 && held < 20) step(1'b0, 16'h1A00, 16'h1000);
        for (int i = 0; i < 8; i++) step(1'b0, 16'h1A00, 16'h1B00);

        // One-cycle reset while cooling.
        for (int i = 0; i < 12; i++) step(1'b0, 16'h1A00, 16'h1C00);
        step(1'b1, 16'h1A00, 16'h1C00);
        for (int i = 0; i < 10; i++) step(1'b0, 16'h1A00, 16'h1C00);

        // Lower threshold exactly and with a negative setpoint.
        for (int i = 0; i < 8; i++) step(1'b0, -16'sh0300, -16'sh0380);
        for (int i = 0; i < 8; i++) step(1'b0, -16'sh0300, -16'sh0381);
        for (int i = 0; i < 8; i++) step(1'b0, -16'sh0300, -16'sh0300);

        // Randomized traffic clustered around the band edges.
        sp = 0;
        for (int c = 0; c < 3000; c++) begin
            if (c % 24 == 0) sp = int'($urandom_range(0, 16000)) - 8000;
            sel = int'($urandom_range(0, 9));
            case (sel)
                0: off = HYST_TB;
                1: off = -HYST_TB;
                2: off = 0;
                3: off = HYST_TB + 1;
                4: off = -HYST_TB - 1;
                default: off = int'($urandom_range(0, 1200)) - 600;
            endcase
            step(($urandom_range(0, 59) == 0), sp, sp + off);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
